// File: rtl/instruction_fetch_stage.sv
// Instruction fetch front end: owns the PC, issues single-outstanding fetches over a
// request/response handshake, and drives the IF/ID register through a one-entry skid.
module instruction_fetch_stage #(
   parameter logic [63:0] RESET_PC = 64'h0,
   parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        reset,
   output logic        imem_req,
   output logic [63:0] imem_addr,
   input  logic        imem_ready,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   input  logic        stall,
   input  logic        branch_taken,
   input  logic [63:0] branch_target,
   output logic        if_id_valid,
   output logic [31:0] if_id_instruction,
   output logic [63:0] if_id_inst_addr
);

   typedef enum logic [1:0] {
      ST_REQ     = 2'd0,
      ST_WAIT    = 2'd1,
      ST_DISCARD = 2'd2
   } state_t;

   state_t      state_r;
   state_t      state_next_s;
   logic [63:0] pc_r;
   logic [63:0] issued_pc_r;
   logic        skid_valid_r;
   logic [31:0] skid_inst_r;
   logic [63:0] skid_addr_r;
   logic        if_id_valid_r;
   logic [31:0] if_id_inst_r;
   logic [63:0] if_id_addr_r;
   logic        req_s;
   logic        accept_s;
   logic        new_inst_s;

   // FSM state register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r <= ST_REQ;
      end else begin
         state_r <= state_next_s;
      end
   end

   // FSM next-state logic; a response arriving in WAIT always returns to REQ, even when dropped
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         ST_REQ: begin
            if (accept_s) begin
               state_next_s = ST_WAIT;
            end else begin
               state_next_s = ST_REQ;
            end
         end
         ST_WAIT: begin
            if (imem_rvalid) begin
               state_next_s = ST_REQ;
            end else if (branch_taken) begin
               state_next_s = ST_DISCARD;
            end else begin
               state_next_s = ST_WAIT;
            end
         end
         ST_DISCARD: begin
            if (imem_rvalid) begin
               state_next_s = ST_REQ;
            end else begin
               state_next_s = ST_DISCARD;
            end
         end
         default: begin
            state_next_s = ST_REQ;
         end
      endcase
   end

   // FSM outputs: request is withheld while the skid holds an instruction or a redirect is live
   always_comb begin
      req_s      = (state_r == ST_REQ) && !branch_taken && !skid_valid_r;
      accept_s   = req_s && imem_ready;
      new_inst_s = (state_r == ST_WAIT) && imem_rvalid && !branch_taken;
   end

   assign imem_req  = req_s;
   assign imem_addr = pc_r;

   // Program counter and the address of the request in flight
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc_r        <= RESET_PC;
         issued_pc_r <= 64'h0;
      end else begin
         if (branch_taken) begin
            pc_r <= branch_target;
         end else if (accept_s) begin
            pc_r <= pc_r + 64'd4;
         end else begin
            pc_r <= pc_r;
         end
         if (accept_s) begin
            issued_pc_r <= pc_r;
         end else begin
            issued_pc_r <= issued_pc_r;
         end
      end
   end

   // IF/ID register and skid: flush beats stall, skid drains before any new response
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         skid_valid_r  <= 1'b0;
         skid_inst_r   <= 32'h0;
         skid_addr_r   <= 64'h0;
         if_id_valid_r <= 1'b0;
         if_id_inst_r  <= NOP_INST;
         if_id_addr_r  <= 64'h0;
      end else if (branch_taken) begin
         skid_valid_r  <= 1'b0;
         if_id_valid_r <= 1'b0;
         if_id_inst_r  <= NOP_INST;
      end else if (stall) begin
         if (new_inst_s) begin
            skid_valid_r <= 1'b1;
            skid_inst_r  <= imem_rdata;
            skid_addr_r  <= issued_pc_r;
         end else begin
            skid_valid_r <= skid_valid_r;
         end
      end else if (skid_valid_r) begin
         skid_valid_r  <= 1'b0;
         if_id_valid_r <= 1'b1;
         if_id_inst_r  <= skid_inst_r;
         if_id_addr_r  <= skid_addr_r;
      end else if (new_inst_s) begin
         if_id_valid_r <= 1'b1;
         if_id_inst_r  <= imem_rdata;
         if_id_addr_r  <= issued_pc_r;
      end else begin
         if_id_valid_r <= 1'b0;
         if_id_inst_r  <= NOP_INST;
      end
   end

   assign if_id_valid       = if_id_valid_r;
   assign if_id_instruction = if_id_inst_r;
   assign if_id_inst_addr   = if_id_addr_r;

endmodule

// File: doc/instruction_fetch_stage.md
# instruction_fetch_stage

- Front end of the pipelined RV64 core: owns the program counter and issues fetches to instruction memory over a request/response handshake.
- Buffers at most one returned instruction and drives the IF/ID pipeline register with a valid bit.
- Applies the stall from the hazard unit and the branch redirect/flush resolved in EX/MEM.
- Sits directly upstream of the decode stage (instruction parser, immediate extractor, register file) and replaces the free-running PC, PC+4 adder, PC mux and IF/ID buffer.

## Interface
Parameters:
- RESET_PC, 64'h0, PC value loaded on reset.
- NOP_INST, 32'h00000013, instruction word presented on a bubble (addi x0,x0,0).

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- imem_req  out  1  fetch request valid.
- imem_addr  out  64  fetch address (= pc).
- imem_ready  in  1  memory accepts the request this cycle.
- imem_rvalid  in  1  response valid.
- imem_rdata  in  32  response instruction word.
- stall  in  1  hold IF/ID and stop loading new instructions (load-use hazard).
- branch_taken  in  1  redirect and flush (ALU_Zero && Branch from EX/MEM).
- branch_target  in  64  redirect address.
- if_id_valid  out  1  IF/ID holds a real instruction.
- if_id_instruction  out  32  IF/ID instruction.
- if_id_inst_addr  out  64  IF/ID instruction address.

## Operation
- State: pc (64), issued_pc (64), FSM {REQ, WAIT, DISCARD}, skid register (valid, inst, addr), IF/ID register.
- Single outstanding request. `imem_addr = pc` at all times.
- `imem_req = (state==REQ) && !branch_taken && !skid_valid`.

FSM transitions:
- REQ, branch_taken: pc<=branch_target, stay REQ.
- REQ, imem_req && imem_ready: issued_pc<=pc, pc<=pc+4 (64-bit wrap, no trap), go WAIT.
- WAIT, branch_taken: pc<=branch_target. If imem_rvalid this cycle, drop the response and go REQ; otherwise go DISCARD.
- WAIT, imem_rvalid, no branch: the response {imem_rdata, issued_pc} is the new instruction; go REQ.
- DISCARD: imem_rvalid drops the response and goes REQ. branch_taken updates pc and stays DISCARD.

IF/ID update, in priority order:
1. branch_taken: valid<=0, instruction<=NOP_INST, skid cleared. Flush overrides stall.
2. stall: IF/ID holds. A new instruction arriving this cycle goes into skid.
3. Otherwise:
   - skid_valid: load skid contents and clear skid.
   - Else a new instruction is present: load it.
   - Else insert a bubble (valid 0, NOP_INST, addr unchanged).
- Skid and a new response cannot coexist: imem_req is blocked while skid is valid.

## Timing
- Reset (reset==0) asynchronously forces:
  - pc=RESET_PC, state=REQ, skid empty.
  - if_id_valid=0, if_id_instruction=NOP_INST, if_id_inst_addr=0.
  - imem_req=1 on the first cycle after reset release.
- Reset asserted mid-transaction: abandon the in-flight request. Memory responses after release in state REQ are ignored.
- Latency: request accepted in cycle N, response in cycle N+k (k≥1). The instruction is visible at IF/ID outputs after the edge ending the response cycle (when not stalled).
- Peak throughput: one instruction per 2 cycles with k=1. Issue resumes the cycle after the response.
- Redirect in cycle N: pc=branch_target after edge N. The first request to the target is issued in cycle N+1 (REQ), or after the discarded response (DISCARD). Wrong-path instructions never reach if_id_valid=1.
- All outputs except imem_req are registered. imem_req is combinational on state, skid_valid and branch_taken.

## Test plan
- Reset, then imem_ready=1, 1-cycle response, instructions = address-tagged words: IF/ID shows addresses 0x0, 0x4, 0x8 with matching words, valid=1, with bubbles between them.
- stall held 3 cycles while a response for 0x8 arrives: IF/ID holds 0x4. The skid captures 0x8 and imem_req stays low. On release, IF/ID=0x8 next edge, then fetch of 0xC resumes.
- branch_taken with target 0x100 in the same cycle as imem_rvalid for 0xC: response dropped, IF/ID valid=0. Next request has imem_addr=0x100, and 0x100 is the next valid IF/ID entry.
- branch_taken in WAIT with the response delayed 3 cycles (target 0x200): state DISCARD. The late response is dropped. The request to 0x200 issues the cycle after it. No valid=1 for the old address.
- stall and branch_taken asserted together with skid full: if_id_valid=0, skid cleared, pc=target.
- reset pulsed low mid-WAIT, RESET_PC=64'h80: all outputs at reset values immediately. The first request after release is 0x80. Wrap check: pc=64'hFFFF_FFFF_FFFF_FFFC fetch → next imem_addr=0.
